// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT frame geometry and the result collector state encoding.
package fft_pkg;
    localparam int FFT_N  = 1024;
    localparam int FFT_DW = 16;
    localparam int FFT_AW = $clog2(FFT_N);
    typedef enum logic {COLLECT = 1'b0, DRAIN = 1'b1} coll_state_t;
endpackage

// File: rtl/fft_mag_ram.sv
// fft_mag_ram: simple dual-port N x W RAM, one write port, one synchronous 1-cycle read port.
// Ports: clk; we/wa/wd write port; re/ra read request, rd data valid the cycle after re.
module fft_mag_ram #(
    parameter int N = 1024,
    parameter int W = 17,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [W-1:0]  wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [W-1:0]  rd
);
    logic [W-1:0] mem [N];
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        if (re) rd <= mem[ra];
    end
endmodule

// File: rtl/fft_result_collector.sv
// fft_result_collector: stores one FFT frame as L1 magnitudes, tracks the peak bin, replays it over valid/ready.
// Ports: clk, reset (async, active low); in_real/in_imag/in_valid FFT stream, rx_ready while collecting;
// frame_done pulse, peak_bin/peak_mag of last frame; out_mag/out_bin/out_last/out_valid/out_ready replay;
// overrun sticky flag for bins dropped outside COLLECT.
module fft_result_collector
    import fft_pkg::*;
#(
    parameter int N = FFT_N,
    parameter int DW = FFT_DW,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in_real,
    input  logic [DW-1:0] in_imag,
    input  logic          in_valid,
    output logic          rx_ready,
    output logic          frame_done,
    output logic [AW-1:0] peak_bin,
    output logic [DW:0]   peak_mag,
    output logic [DW:0]   out_mag,
    output logic [AW-1:0] out_bin,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          overrun
);
    coll_state_t state;
    logic signed [DW:0] re_x, im_x;
    logic [DW:0] abs_re, abs_im, mag, mag_q, ram_q, sk_mag, run_max, cur_max;
    logic [AW-1:0] wr_idx, rd_idx, rd_bin, sk_bin, run_bin, cur_bin, ld_bin;
    logic mag_v, wr, wr_last, take, rd_v, rd_done, sk_v, pop, ld_out, nxt_sk_v, issue, have;

    assign re_x = {in_real[DW-1], in_real};
    assign im_x = {in_imag[DW-1], in_imag};
    assign abs_re = re_x[DW] ? -re_x : re_x;
    assign abs_im = im_x[DW] ? -im_x : im_x;
    assign mag = abs_re + abs_im;

    assign rx_ready = state == COLLECT;
    // a sample already in the mag stage when the frame closes is dropped, not written into the replay
    assign wr = mag_v && rx_ready;
    assign wr_last = wr && wr_idx == AW'(N - 1);
    // strictly greater keeps the lowest bin on ties; bin 0 restarts the running max
    assign take = wr_idx == '0 || mag_q > run_max;
    assign cur_max = take ? mag_q : run_max;
    assign cur_bin = take ? wr_idx : run_bin;

    // replay pipeline: RAM read (rd_v) -> skid -> output register; a read is issued only
    // when the skid is guaranteed empty next cycle so a stall never loses a beat
    assign pop = out_valid && out_ready;
    assign ld_out = !out_valid || pop;
    assign have = sk_v || rd_v;
    assign ld_bin = sk_v ? sk_bin : rd_bin;
    assign nxt_sk_v = ld_out ? sk_v && rd_v : have;
    assign issue = state == DRAIN && !rd_done && !nxt_sk_v;

    fft_mag_ram #(.N(N), .W(DW + 1)) u_ram (
        .clk(clk),
        .we(wr),
        .wa(wr_idx),
        .wd(mag_q),
        .re(issue),
        .ra(rd_idx),
        .rd(ram_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= COLLECT;
            mag_v <= 1'b0;
            mag_q <= '0;
            overrun <= 1'b0;
            frame_done <= 1'b0;
            wr_idx <= '0;
            run_max <= '0;
            run_bin <= '0;
            peak_mag <= '0;
            peak_bin <= '0;
            rd_v <= 1'b0;
            rd_bin <= '0;
            rd_idx <= '0;
            rd_done <= 1'b0;
            sk_v <= 1'b0;
            sk_mag <= '0;
            sk_bin <= '0;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            out_mag <= '0;
            out_bin <= '0;
        end else begin
            mag_v <= in_valid && rx_ready;
            mag_q <= mag;
            overrun <= overrun || (in_valid && !rx_ready) || (mag_v && !rx_ready);
            frame_done <= wr_last;
            if (wr) begin
                wr_idx <= wr_idx + 1'b1;
                run_max <= cur_max;
                run_bin <= cur_bin;
            end
            if (wr_last) begin
                peak_mag <= cur_max;
                peak_bin <= cur_bin;
                state <= DRAIN;
            end
            rd_v <= issue;
            if (issue) begin
                rd_bin <= rd_idx;
                rd_idx <= rd_idx + 1'b1;
                rd_done <= rd_idx == AW'(N - 1);
            end
            sk_v <= nxt_sk_v;
            if (ld_out ? sk_v && rd_v : rd_v) begin
                sk_mag <= ram_q;
                sk_bin <= rd_bin;
            end
            if (ld_out) begin
                out_valid <= have;
                out_last <= have && ld_bin == AW'(N - 1);
                if (have) begin
                    out_mag <= sk_v ? sk_mag : ram_q;
                    out_bin <= ld_bin;
                end
            end
            if (pop && out_last) begin
                state <= COLLECT;
                rd_done <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fft_result_collector.sv
// tb_fft_result_collector: directed frames with hand-computed peaks, replay order/stall/timing checks.
module tb_fft_result_collector;
    import fft_pkg::*;
    localparam int N = FFT_N;
    localparam int DW = FFT_DW;
    localparam int AW = FFT_AW;

    logic clk = 1'b0;
    logic reset, in_valid, rx_ready, frame_done, out_last, out_valid, out_ready, overrun;
    logic [DW-1:0] in_real, in_imag;
    logic [AW-1:0] peak_bin, out_bin;
    logic [DW:0] peak_mag, out_mag;
    int n_chk = 0, n_pass = 0;
    int re_a[N], im_a[N], exp_m[N];

    always #5 clk = ~clk;

    fft_result_collector dut (
        .clk(clk), .reset(reset), .in_real(in_real), .in_imag(in_imag), .in_valid(in_valid),
        .rx_ready(rx_ready), .frame_done(frame_done), .peak_bin(peak_bin), .peak_mag(peak_mag),
        .out_mag(out_mag), .out_bin(out_bin), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .overrun(overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int mag_of(input int re, input int im);
        return (re < 0 ? -re : re) + (im < 0 ? -im : im);
    endfunction

    task automatic send(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            in_real = DW'(re_a[k]);
            in_imag = DW'(im_a[k]);
            in_valid = 1'b1;
            exp_m[k] = mag_of(re_a[k], im_a[k]);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input int pb, input int pm);
        send(N);
        check("fd_early", frame_done, 0);
        check("rdy_early", rx_ready, 1);
        @(negedge clk);
        check("frame_done", frame_done, 1);
        check("rdy_drop", rx_ready, 0);
        check("peak_bin", peak_bin, pb);
        check("peak_mag", peak_mag, pm);
        @(negedge clk);
        check("fd_pulse", frame_done, 0);
        check("ov_gap", out_valid, 0);
    endtask

    task automatic drain(input int rnd, input int ovr);
        int beat = 0, cyc = 0, first = -1, last = 0, fd_n = 0;
        logic stall = 1'b0;
        logic [31:0] snap = '0;
        while (beat < N && cyc < 8 * N) begin
            @(negedge clk);
            cyc++;
            if (frame_done) fd_n++;
            if (stall) check("stall_hold", {out_valid, out_last, out_bin, out_mag}, snap);
            out_ready = rnd != 0 ? $urandom_range(0, 1) == 1 : 1'b1;
            in_valid = ovr != 0 && cyc % 37 == 5;
            in_real = DW'($urandom);
            in_imag = DW'($urandom);
            if (out_valid && out_ready) begin
                check("out_bin", out_bin, beat);
                check("out_mag", out_mag, exp_m[beat]);
                check("out_last", out_last, beat == N - 1);
                if (first < 0) first = cyc;
                last = cyc;
                beat++;
            end
            stall = out_valid && !out_ready;
            snap = {out_valid, out_last, out_bin, out_mag};
        end
        check("beats", beat, N);
        check("drain_fd", fd_n, 0);
        if (rnd == 0) begin
            check("first_beat", first, 1);
            check("span", last - first, N - 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("ov_end", out_valid, 0);
        check("rdy_back", rx_ready, 1);
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        in_real = '0;
        in_imag = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rdy", rx_ready, 1);
        check("rst_fd", frame_done, 0);
        check("rst_pb", peak_bin, 0);
        check("rst_pm", peak_mag, 0);
        check("rst_om", out_mag, 0);
        check("rst_ob", out_bin, 0);
        check("rst_ol", out_last, 0);
        check("rst_ov", out_valid, 0);
        check("rst_ovr", overrun, 0);
        reset = 1'b1;

        for (int k = 0; k < N; k++) begin re_a[k] = k; im_a[k] = 0; end
        collect(1023, 1023);
        drain(0, 0);

        for (int k = 0; k < N; k++) begin re_a[k] = 1; im_a[k] = -1; end
        re_a[5] = -32768;
        im_a[5] = -32768;
        collect(5, 65536);
        drain(1, 0);
        check("ovr_clean", overrun, 0);

        for (int k = 0; k < N; k++) begin re_a[k] = 0; im_a[k] = 0; end
        re_a[10] = 500;
        re_a[900] = -250;
        im_a[900] = 250;
        collect(10, 500);
        drain(0, 1);
        check("ovr_set", overrun, 1);

        for (int k = 0; k < N; k++) begin re_a[k] = 3 * k - 1500; im_a[k] = -k; end
        collect(1023, 2592);
        drain(1, 0);
        check("ovr_sticky", overrun, 1);

        for (int k = 0; k < 300; k++) begin re_a[k] = 5000; im_a[k] = 5000; end
        send(300);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_ovr", overrun, 0);
        check("mid_rst_rdy", rx_ready, 1);
        check("mid_rst_pm", peak_mag, 0);
        reset = 1'b1;
        for (int k = 0; k < N; k++) begin re_a[k] = 0; im_a[k] = k % 100; end
        im_a[77] = -4000;
        collect(77, 4000);
        drain(0, 0);
        check("ovr_final", overrun, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
